// File: rtl/define_accum_if.sv
// define_accum_if: sample input and frame-total output handshakes of define_accum.
// The master side produces samples and consumes frame totals; the slave side is the accumulator.
interface define_accum_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int FRAME_LEN = 4
);
  logic [WIDTH-1:0]                   in_data;
  logic                               in_valid;
  logic                               in_ready;
  logic [ACC_WIDTH-1:0]               out_sum;
  logic [$clog2(FRAME_LEN+1)-1:0]     out_count;
  logic                               overflow;
  logic                               out_valid;
  logic                               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sum, out_count, overflow, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sum, out_count, overflow, out_valid
  );
endinterface

// File: rtl/define_accum.sv
// define_accum: buffers add_define samples in a small FIFO, sums fixed-length
// frames with saturation and hands each frame total out on a valid/ready port.
module define_accum #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  define_accum_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN + 1);

  localparam logic [0:0] ST_ACCUM  = 1'b0;
  localparam logic [0:0] ST_REPORT = 1'b1;

  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;

  // Frame accumulator and output handshake state
  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0]        out_count_q, out_count_d;
  logic                 overflow_q, overflow_d;
  logic                 out_valid_q, out_valid_d;

  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic [WIDTH-1:0]     pop_data_s;
  logic [ACC_WIDTH:0]   sum_ext_s;
  logic [CW-1:0]        count_inc_s;

  // FIFO status, handshake qualifiers and the widened saturating-add operand
  always_comb begin
    full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_s     = (wr_ptr_q == rd_ptr_q);
    push_s      = bus.in_valid && !full_s;
    pop_s       = (state_q == ST_ACCUM) && !empty_s;
    pop_data_s  = mem_q[rd_ptr_q[AW-1:0]];
    sum_ext_s   = {1'b0, out_sum_q} + (ACC_WIDTH+1)'(pop_data_s);
    count_inc_s = out_count_q + CW'(1);
  end

  // Next-state logic: clear wins, otherwise push/pop/accumulate/report
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      state_d     = ST_ACCUM;
      out_sum_d   = '0;
      out_count_d = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      // Push uses the full flag from the registered pointers: no same-cycle bypass
      if (push_s) begin
        mem_d[wr_ptr_q[AW-1:0]] = bus.in_data;
        wr_ptr_d                = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      case (state_q)
        ST_ACCUM: begin
          if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            out_count_d = count_inc_s;
            if (sum_ext_s[ACC_WIDTH]) begin
              out_sum_d  = '1;
              overflow_d = 1'b1;
            end else begin
              out_sum_d  = sum_ext_s[ACC_WIDTH-1:0];
              overflow_d = overflow_q;
            end
            if (count_inc_s == FRAME_LEN_C) begin
              state_d     = ST_REPORT;
              out_valid_d = 1'b1;
            end else begin
              state_d     = ST_ACCUM;
              out_valid_d = 1'b0;
            end
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end
        ST_REPORT: begin
          if (bus.out_ready) begin
            state_d     = ST_ACCUM;
            out_sum_d   = '0;
            out_count_d = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
          end else begin
            state_d = ST_REPORT;
          end
        end
        default: begin
          state_d     = ST_ACCUM;
          out_sum_d   = '0;
          out_count_d = '0;
          overflow_d  = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_ACCUM;
      out_sum_q   <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = !full_s;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/define_accum.md
# define_accum

Downstream consumer of the `add_define` stage. It accepts the incremented 16-bit samples through a valid/ready handshake and buffers them in a small FIFO. It sums fixed-length frames of samples with saturation and presents each frame total on an output valid/ready handshake. Test benches and the top level use it to check and report `add_define` results frame by frame, instead of comparing single combinational values.

## Interface
- `WIDTH`, 16, sample width; matches the `add_define` output.
- `ACC_WIDTH`, 24, accumulator width; must be ≥ `WIDTH`.
- `DEPTH`, 4, input FIFO depth; must be a power of two and ≥ 2.
- `FRAME_LEN`, 4, number of samples per reported frame; must be ≥ 1.
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush; ignored while `rst` is high.
- `in_data`  in  `WIDTH`  sample from `add_define`, unsigned.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a sample.
- `out_sum`  out  `ACC_WIDTH`  frame total, unsigned, saturating.
- `out_count`  out  `$clog2(FRAME_LEN+1)`  samples accumulated in the current frame.
- `overflow`  out  1  saturation occurred in the current frame; sticky.
- `out_valid`  out  1  frame total is ready to be taken.
- `out_ready`  in  1  consumer takes the frame total.

## Operation
- Reset values: FIFO empty, `in_ready`=1, `out_sum`=0, `out_count`=0, `overflow`=0, `out_valid`=0, state `ACCUM`.
- FIFO
  - Push when `in_valid && in_ready`.
  - `in_ready` = FIFO not full.
  - There is no bypass. When the FIFO is full, `in_ready`=0 and no push happens, even if a pop occurs in the same cycle.
  - The FIFO keeps accepting samples in every state.
- Pointers: `$clog2(DEPTH)+1` bits wide; they wrap modulo 2·`DEPTH`.
  - Full: MSBs differ and the low bits are equal.
  - Empty: the pointers are equal.
- State `ACCUM`: on any cycle with the FIFO non-empty, pop one sample.
  - Sample is zero-extended to `ACC_WIDTH` and added to `out_sum`.
  - `out_count` increments by 1.
  - If the true sum exceeds 2^`ACC_WIDTH`−1, `out_sum` holds all-ones and `overflow` is set.
  - When a pop brings `out_count` to `FRAME_LEN`, move to `REPORT` on the same edge.
- State `REPORT`:
  - `out_valid`=1; no pops occur.
  - `out_sum`, `out_count` and `overflow` are held stable.
  - On an edge with `out_valid && out_ready`: `out_sum`, `out_count` and `overflow` go to 0 and the state returns to `ACCUM`. The next pop can happen on the following edge.
- `clear`: on the next edge, the FIFO is emptied and `out_sum`, `out_count`, `overflow` and `out_valid` go to 0; state becomes `ACCUM`.
  - `clear` has priority over push, pop and the output handshake.
  - A sample offered in the same cycle as `clear` is dropped.
- `rst` asserted at any time, including mid-frame or in `REPORT`: all outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Sample pushed at edge N is added to `out_sum` at edge N+1 at the earliest.
- Pop throughput: one sample per cycle.
- With back-to-back pushes at edges 1..`FRAME_LEN`:
  - pops occur at edges 2..`FRAME_LEN`+1;
  - `out_valid` is high after edge `FRAME_LEN`+1.
- Frame handshake: one cycle minimum with `out_ready` held high. The sustained rate is then `FRAME_LEN` samples per `FRAME_LEN`+1 cycles.
- All outputs are registered, except `in_ready`, which is decoded from registered pointers. There is no combinational path from any input to any output.

## Test plan
- **Reset:** assert `rst` asynchronously between edges.
  - Required: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `overflow`=0 immediately, before the next edge.
- **Nominal frame:** push 16,16,16,16 on consecutive edges 1–4 with `out_ready`=1.
  - Required: `out_valid` high after edge 5 with `out_sum`=64, `out_count`=4, `overflow`=0.
  - Handshake at edge 6, after which `out_sum`=0.
- **Backpressure:** hold `out_ready`=0 and offer 9 samples of value 1.
  - Required: first frame reports `out_sum`=4; samples 5–8 fill the FIFO; `in_ready`=0; sample 9 stalls.
  - Raise `out_ready`: sample 9 is accepted and the second frame reports `out_sum`=4.
- **Saturation** (`ACC_WIDTH`=17): push 0xFFFF four times.
  - Required: `out_sum`=0x1FFFF, `overflow`=1.
  - The next frame of four 1s reports `out_sum`=4, `overflow`=0.
- **Clear mid-frame:** after two samples of 5, pulse `clear` in the same cycle as a third sample of 5. Then push 1,2,3,4.
  - Required: `out_count`=0 after the clear edge; the third 5 is dropped; frame reports `out_sum`=10.
- **Reset in REPORT:** assert `rst` while `out_valid`=1. Release it, then push 2,2,2,2.
  - Required: `out_valid` drops immediately; next frame reports `out_sum`=8.
